// File: rtl/axi4_pkg.sv
// Shared AXI4 read-channel constants and the read-arbiter FSM state type.
package axi4_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rd_arb_grant.sv
// Combinational grant selection for axi4_rd_arbiter.
// AXI_RD_ARB_RR_EN: round-robin search starting at ptr; otherwise fixed priority, highest index wins.
module rd_arb_grant #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
`ifdef AXI_RD_ARB_RR_EN
    input  logic [IDX_W-1:0]       ptr,
`endif
    output logic                   gnt_valid,
    output logic [NUM_MASTERS-1:0] gnt_oh,
    output logic [IDX_W-1:0]       gnt_idx
);

    assign gnt_valid = |req;

    always_comb begin
        // NOTE: every output gets a default before any conditional logic, so no latch is inferred.
        gnt_idx = '0;
        gnt_oh  = '0;
`ifdef AXI_RD_ARB_RR_EN
        // Walk offsets downward so the requester closest to ptr is the last (winning) assignment.
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_MASTERS]) begin
                gnt_idx = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
            end
        end
`else
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (req[k]) begin
                gnt_idx = IDX_W'(k);
            end
        end
`endif
        if (gnt_valid) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Shares one AXI4 AR/R master port among NUM_MASTERS requesters, one burst outstanding.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; default is fixed priority (highest index).
module axi4_rd_arbiter
    import axi4_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        req_arvalid,
    output logic [NUM_MASTERS-1:0]        req_arready,
    input  logic [NUM_MASTERS*ADDR_W-1:0] req_araddr,
    input  logic [NUM_MASTERS*8-1:0]      req_arlen,
    output logic [NUM_MASTERS-1:0]        req_rvalid,
    input  logic [NUM_MASTERS-1:0]        req_rready,
    output logic [DATA_W-1:0]             req_rdata,
    output logic                          req_rlast,
    output logic [ID_W-1:0]               m_arid,
    output logic [ADDR_W-1:0]             m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [ID_W-1:0]               m_rid,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic                          busy,
    output logic                          proto_err
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [ADDR_W-1:0] m_araddr_q, m_araddr_d;
    logic [7:0]        m_arlen_q, m_arlen_d;
    logic [ID_W-1:0]   m_arid_q, m_arid_d;
    logic              m_arvalid_q, m_arvalid_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              proto_err_q, proto_err_d;
`ifdef AXI_RD_ARB_RR_EN
    logic [IDX_W-1:0]  ptr_q, ptr_d;
`endif

    logic                   gnt_valid;
    logic [NUM_MASTERS-1:0] gnt_oh;
    logic [IDX_W-1:0]       gnt_idx;
    logic [ADDR_W-1:0]      addr_arr [NUM_MASTERS];
    logic [7:0]             len_arr  [NUM_MASTERS];
    logic                   r_beat;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign addr_arr[i] = req_araddr[i*ADDR_W +: ADDR_W];
        assign len_arr[i]  = req_arlen[i*8 +: 8];
    end

    rd_arb_grant #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_grant (
        .req       (req_arvalid),
`ifdef AXI_RD_ARB_RR_EN
        .ptr       (ptr_q),
`endif
        .gnt_valid (gnt_valid),
        .gnt_oh    (gnt_oh),
        .gnt_idx   (gnt_idx)
    );

    // Upstream handshakes are combinational; R is routed only to the latched grant.
    always_comb begin
        req_arready = '0;
        req_rvalid  = '0;
        m_rready    = 1'b0;
        if (state_q == IDLE) begin
            req_arready = gnt_oh;
        end
        if (state_q == DATA) begin
            m_rready            = req_rready[grant_q];
            req_rvalid[grant_q] = m_rvalid;
        end
    end

    assign r_beat = (state_q == DATA) && m_rvalid && m_rready;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        m_araddr_d  = m_araddr_q;
        m_arlen_d   = m_arlen_q;
        m_arid_d    = m_arid_q;
        m_arvalid_d = m_arvalid_q;
        beat_cnt_d  = beat_cnt_q;
        proto_err_d = proto_err_q;
`ifdef AXI_RD_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d     = gnt_idx;
                    m_araddr_d  = addr_arr[gnt_idx];
                    m_arlen_d   = len_arr[gnt_idx];
                    m_arid_d    = ID_W'(gnt_idx);
                    m_arvalid_d = 1'b1;
                    state_d     = ADDR;
`ifdef AXI_RD_ARB_RR_EN
                    ptr_d       = IDX_W'((int'(gnt_idx) + 1) % NUM_MASTERS);
`endif
                end
            end
            ADDR: begin
                if (m_arready) begin
                    m_arvalid_d = 1'b0;
                    beat_cnt_d  = 8'd0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (r_beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (m_rid != ID_W'(grant_q)) begin
                        proto_err_d = 1'b1;
                    end
                    // rlast must coincide exactly with the beat numbered m_arlen.
                    if (m_rlast != (beat_cnt_q == m_arlen_q)) begin
                        proto_err_d = 1'b1;
                    end
                    if (m_rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != DATA && m_rvalid) begin
            proto_err_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state logic is in always_comb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            m_araddr_q  <= '0;
            m_arlen_q   <= '0;
            m_arid_q    <= '0;
            m_arvalid_q <= 1'b0;
            beat_cnt_q  <= '0;
            proto_err_q <= 1'b0;
`ifdef AXI_RD_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            m_araddr_q  <= m_araddr_d;
            m_arlen_q   <= m_arlen_d;
            m_arid_q    <= m_arid_d;
            m_arvalid_q <= m_arvalid_d;
            beat_cnt_q  <= beat_cnt_d;
            proto_err_q <= proto_err_d;
`ifdef AXI_RD_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign m_arid    = m_arid_q;
    assign m_araddr  = m_araddr_q;
    assign m_arlen   = m_arlen_q;
    assign m_arvalid = m_arvalid_q;
    assign m_arsize  = SIZE_4B;
    assign m_arburst = BURST_INCR;
    assign req_rdata = m_rdata;
    assign req_rlast = m_rlast;
    assign busy      = (state_q != IDLE);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Self-checking bench for axi4_rd_arbiter (2 masters); R beats are scoreboarded
// downstream-side and compared on the requester side. Expects AXI_RD_ARB_RR_EN to match the RTL build.
`timescale 1ns/1ps
module tb_axi4_rd_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    typedef struct packed {
        logic [1:0]  master;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NM-1:0]     req_arvalid = '0;
    logic [NM-1:0]     req_arready;
    logic [NM*AW-1:0]  req_araddr = '0;
    logic [NM*8-1:0]   req_arlen = '0;
    logic [NM-1:0]     req_rvalid;
    logic [NM-1:0]     req_rready = '1;
    logic [DW-1:0]     req_rdata;
    logic              req_rlast;
    logic [IW-1:0]     m_arid;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready = 1'b0;
    logic [IW-1:0]     m_rid = '0;
    logic [DW-1:0]     m_rdata = '0;
    logic              m_rlast = 1'b0;
    logic              m_rvalid = 1'b0;
    logic              m_rready;
    logic              busy;
    logic              proto_err;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] seq = 32'hD000_0000;

    axi4_rd_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .ID_W        (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_arvalid (req_arvalid),
        .req_arready (req_arready),
        .req_araddr  (req_araddr),
        .req_arlen   (req_arlen),
        .req_rvalid  (req_rvalid),
        .req_rready  (req_rready),
        .req_rdata   (req_rdata),
        .req_rlast   (req_rlast),
        .m_arid      (m_arid),
        .m_araddr    (m_araddr),
        .m_arlen     (m_arlen),
        .m_arsize    (m_arsize),
        .m_arburst   (m_arburst),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rid       (m_rid),
        .m_rdata     (m_rdata),
        .m_rlast     (m_rlast),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [31:0] addr, input logic [7:0] len);
        req_araddr[i*AW +: AW] = addr;
        req_arlen[i*8 +: 8]    = len;
    endtask

    task automatic do_reset();
        req_arvalid = '0;
        req_rready  = '1;
        m_rvalid    = 1'b0;
        m_rlast     = 1'b0;
        m_arready   = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    // Waits (bounded) for the upstream accept pulse, then plays the AR slave.
    // Returns what the DUT showed; callers compare against their own expectations.
    task automatic accept_ar(input int ar_wait, input bit drop,
                             output logic [1:0] rdy, output int waited,
                             output logic [3:0] arid, output logic [31:0] araddr,
                             output logic [7:0] arlen, output logic arv, output logic stable);
        waited = 0;
        @(negedge clk);
        while (req_arready == '0 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        rdy = req_arready;
        @(posedge clk);
        #1;
        if (drop) req_arvalid = req_arvalid & ~rdy;
        @(negedge clk);
        arv    = m_arvalid;
        arid   = m_arid;
        araddr = m_araddr;
        arlen  = m_arlen;
        stable = (req_arready == '0);
        repeat (ar_wait) begin
            @(negedge clk);
            if (m_arvalid !== 1'b1 || m_araddr !== araddr || m_arlen !== arlen ||
                m_arid !== arid || req_arready !== '0)
                stable = 1'b0;
        end
        m_arready = 1'b1;
        @(posedge clk);
        #1 m_arready = 1'b0;
    endtask

    // Plays the R slave for n_serve of n beats; expected beats are pushed on each
    // downstream handshake and popped when the requester side shows a beat.
    task automatic serve_burst(input int g, input int n, input int n_serve,
                               input int stall_at, input int stall_len, input int bad_beat,
                               output int stall_obs, output logic busy_last);
        int    tries;
        int    stall_left;
        bit    done;
        beat_t e;
        beat_t o;
        stall_obs = 0;
        busy_last = 1'b0;
        stall_left = 0;
        for (int b = 0; b < n_serve; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = seq;
            m_rlast  = (b == n - 1);
            m_rid    = (b == bad_beat) ? 4'(g ^ 1) : 4'(g);
            if (b == stall_at && stall_len > 0) begin
                req_rready[g] = 1'b0;
                stall_left = stall_len;
            end
            tries = 0;
            done  = 1'b0;
            while (!done && tries < 12) begin
                @(negedge clk);
                busy_last = busy;
                if (m_rready === 1'b1)
                    exp_q.push_back('{master: 2'(1 << g), data: seq, last: (b == n - 1)});
                if ((req_rvalid & req_rready) != '0) begin
                    o = '{master: req_rvalid, data: req_rdata, last: req_rlast};
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL beat_unexpected: got rvalid=%b data=%h last=%b, expected no beat",
                                 o.master, o.data, o.last);
                    end else begin
                        e = exp_q.pop_front();
                        if (o !== e) begin
                            n_errors++;
                            $display("FAIL beat_data: got rvalid=%b data=%h last=%b, expected rvalid=%b data=%h last=%b",
                                     o.master, o.data, o.last, e.master, e.data, e.last);
                        end
                    end
                end
                if (m_rready === 1'b1) done = 1'b1;
                else stall_obs++;
                @(posedge clk);
                #1;
                if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) req_rready[g] = 1'b1;
                end
                tries++;
            end
            n_checks++;
            if (!done) begin
                n_errors++;
                $display("FAIL beat_timeout: beat %0d not accepted within %0d cycles", b, tries);
            end
            seq = seq + 32'd1;
        end
        if (n_serve == n) begin
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({busy, m_arvalid, m_rready, proto_err} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy/arvalid/rready/perr=%b expected 0000",
                     {busy, m_arvalid, m_rready, proto_err});
        end
        n_checks++;
        if ({req_arready, req_rvalid} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_req: arready/rvalid=%b expected 0000", {req_arready, req_rvalid});
        end
        n_checks++;
        if ({m_arid, m_araddr, m_arlen} !== 44'h0) begin
            n_errors++;
            $display("FAIL reset_ar: arid=%h addr=%h len=%h expected 0", m_arid, m_araddr, m_arlen);
        end
        n_checks++;
        if ({m_arsize, m_arburst} !== 5'b010_01) begin
            n_errors++;
            $display("FAIL fixed_fields: size=%b burst=%b expected 010 01", m_arsize, m_arburst);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0]  rdy;
        int          waited;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic        arv, stable, busy_last;
        int          stall_obs;
        set_req(0, 32'h1C00_0000, 8'd3);
        @(posedge clk);
        #1 req_arvalid = 2'b01;
        accept_ar(1, 1'b1, rdy, waited, arid, araddr, arlen, arv, stable);
        n_checks++;
        if (rdy !== 2'b01 || waited !== 0) begin
            n_errors++;
            $display("FAIL single_accept: arready=%b after %0d cycles, expected 01 after 0", rdy, waited);
        end
        n_checks++;
        if ({arv, arid, araddr, arlen} !== {1'b1, 4'd0, 32'h1C00_0000, 8'd3}) begin
            n_errors++;
            $display("FAIL single_ar: valid=%b id=%h addr=%h len=%h expected 1 0 1c000000 03",
                     arv, arid, araddr, arlen);
        end
        n_checks++;
        if (stable !== 1'b1) begin
            n_errors++;
            $display("FAIL single_ar_stable: stable=%b expected 1", stable);
        end
        serve_burst(0, 4, 4, -1, 0, -1, stall_obs, busy_last);
        n_checks++;
        if (exp_q.size() != 0 || stall_obs != 0) begin
            n_errors++;
            $display("FAIL single_beats: undelivered=%0d stalls=%0d expected 0 0", exp_q.size(), stall_obs);
        end
        @(negedge clk);
        n_checks++;
        if ({busy_last, busy, proto_err, req_arready} !== 5'b10000) begin
            n_errors++;
            $display("FAIL single_end: busy_at_last=%b busy=%b perr=%b arready=%b expected 1 0 0 00",
                     busy_last, busy, proto_err, req_arready);
        end
    endtask

    task automatic test_priority();
        logic [1:0]  rdy;
        int          waited;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic        arv, stable, busy_last;
        int          stall_obs;
        set_req(0, 32'h0000_1000, 8'd1);
        set_req(1, 32'h8000_2000, 8'd2);
        @(posedge clk);
        #1 req_arvalid = 2'b11;
        accept_ar(0, 1'b1, rdy, waited, arid, araddr, arlen, arv, stable);
        n_checks++;
        if ({rdy, arid, araddr, arlen, stable} !== {2'b10, 4'd1, 32'h8000_2000, 8'd2, 1'b1}) begin
            n_errors++;
            $display("FAIL prio_first: arready=%b id=%h addr=%h len=%h stable=%b expected 10 1 80002000 02 1",
                     rdy, arid, araddr, arlen, stable);
        end
        serve_burst(1, 3, 3, -1, 0, -1, stall_obs, busy_last);
        accept_ar(0, 1'b1, rdy, waited, arid, araddr, arlen, arv, stable);
        n_checks++;
        if ({rdy, arid, araddr, arlen} !== {2'b01, 4'd0, 32'h0000_1000, 8'd1} || waited !== 0) begin
            n_errors++;
            $display("FAIL prio_second: arready=%b id=%h addr=%h len=%h wait=%0d expected 01 0 00001000 01 0",
                     rdy, arid, araddr, arlen, waited);
        end
        serve_burst(0, 2, 2, -1, 0, -1, stall_obs, busy_last);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL prio_beats: undelivered=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_rr_order();
        logic [1:0]  rdy;
        int          waited;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic        arv, stable, busy_last;
        int          stall_obs;
        int          exp_g [4];
`ifdef AXI_RD_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{1, 1, 1, 1};
`endif
        do_reset();
        set_req(0, 32'h0000_4000, 8'd0);
        set_req(1, 32'h0000_5000, 8'd0);
        @(posedge clk);
        #1 req_arvalid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            accept_ar(0, 1'b0, rdy, waited, arid, araddr, arlen, arv, stable);
            n_checks++;
            if (arid !== 4'(exp_g[k]) || rdy !== 2'(1 << exp_g[k]) || waited !== 0) begin
                n_errors++;
                $display("FAIL order_burst%0d: id=%h arready=%b wait=%0d expected id=%0d wait=0",
                         k, arid, rdy, waited, exp_g[k]);
            end
            serve_burst(exp_g[k], 1, 1, -1, 0, -1, stall_obs, busy_last);
        end
        req_arvalid = 2'b00;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL order_beats: undelivered=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  rdy;
        int          waited;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic        arv, stable, busy_last;
        int          stall_obs;
        set_req(1, 32'h2000_0040, 8'd7);
        @(posedge clk);
        #1 req_arvalid = 2'b10;
        accept_ar(2, 1'b1, rdy, waited, arid, araddr, arlen, arv, stable);
        n_checks++;
        if ({rdy, arid, arlen} !== {2'b10, 4'd1, 8'd7}) begin
            n_errors++;
            $display("FAIL bp_ar: arready=%b id=%h len=%h expected 10 1 07", rdy, arid, arlen);
        end
        serve_burst(1, 8, 8, 3, 3, -1, stall_obs, busy_last);
        n_checks++;
        if (stall_obs !== 3) begin
            n_errors++;
            $display("FAIL bp_stall: rready low for %0d cycles, expected 3", stall_obs);
        end
        n_checks++;
        if (exp_q.size() != 0 || proto_err !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_end: undelivered=%0d perr=%b expected 0 0", exp_q.size(), proto_err);
        end
    endtask

    task automatic test_bad_id();
        logic [1:0]  rdy;
        int          waited;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic        arv, stable, busy_last;
        int          stall_obs;
        set_req(0, 32'h1C00_0100, 8'd3);
        @(posedge clk);
        #1 req_arvalid = 2'b01;
        accept_ar(0, 1'b1, rdy, waited, arid, araddr, arlen, arv, stable);
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_errors++;
            $display("FAIL badid_pre: perr=%b expected 0", proto_err);
        end
        serve_burst(0, 4, 4, -1, 0, 1, stall_obs, busy_last);
        n_checks++;
        if (proto_err !== 1'b1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL badid_flag: perr=%b undelivered=%0d expected 1 0", proto_err, exp_q.size());
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_errors++;
            $display("FAIL badid_sticky: perr=%b expected 1", proto_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  rdy;
        int          waited;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic        arv, stable, busy_last;
        int          stall_obs;
        set_req(0, 32'h1C00_0200, 8'd3);
        @(posedge clk);
        #1 req_arvalid = 2'b01;
        accept_ar(0, 1'b1, rdy, waited, arid, araddr, arlen, arv, stable);
        serve_burst(0, 4, 2, -1, 0, -1, stall_obs, busy_last);
        m_rdata = seq;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, m_rready, m_arvalid, req_rvalid, proto_err} !== 6'b0) begin
            n_errors++;
            $display("FAIL async_reset: busy=%b rready=%b arvalid=%b rvalid=%b perr=%b expected all 0",
                     busy, m_rready, m_arvalid, req_rvalid, proto_err);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL reset_beats: undelivered=%0d expected 0", exp_q.size());
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        set_req(1, 32'h3000_0000, 8'd1);
        req_arvalid = 2'b10;
        accept_ar(1, 1'b1, rdy, waited, arid, araddr, arlen, arv, stable);
        n_checks++;
        if ({rdy, arid, araddr, arlen, waited == 0} !== {2'b10, 4'd1, 32'h3000_0000, 8'd1, 1'b1}) begin
            n_errors++;
            $display("FAIL post_reset_ar: arready=%b id=%h addr=%h len=%h wait=%0d expected 10 1 30000000 01 0",
                     rdy, arid, araddr, arlen, waited);
        end
        serve_burst(1, 2, 2, -1, 0, -1, stall_obs, busy_last);
        n_checks++;
        if (exp_q.size() != 0 || proto_err !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_beats: undelivered=%0d perr=%b expected 0 0", exp_q.size(), proto_err);
        end
    endtask

    task automatic test_idle_rvalid();
        @(posedge clk);
        #1;
        m_rvalid = 1'b1;
        m_rid    = 4'd0;
        @(negedge clk);
        n_checks++;
        if ({m_rready, req_rvalid, busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL idle_rvalid_route: rready=%b rvalid=%b busy=%b expected 0 00 0",
                     m_rready, req_rvalid, busy);
        end
        @(posedge clk);
        #1 m_rvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_rvalid_flag: perr=%b expected 1", proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_rr_order();
        test_backpressure();
        test_bad_id();
        test_reset_mid();
        test_idle_rvalid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
